// File: rtl/conv_pe_sequencer.sv
// conv_pe_sequencer
//
// Control sequencer for the convolution PE array. A rising edge on cal_start
// launches a run that emits, for every output pixel, a one-cycle PE_reset
// (accumulator clear) followed cfg_acc_cycles later by a one-cycle PE_finish
// (result strobe). The run supports lane masking, downstream back-pressure
// with a PE hold, abort, and a one-cycle completion pulse.
//
// Optional feature macro: PE_SEQ_PERF_EN
//   defined   -> stall_cycles counts cycles spent stalled on ofm_ready
//   undefined -> stall_cycles is tied to zero
//
// Ports
//   clk             : single clock, rising edge
//   reset           : synchronous, active-high
//   cal_start       : level; rising edge starts a run (only from IDLE)
//   abort           : ends a run in progress, no further PE_finish
//   cfg_start_delay : cycles between start and the first PE_reset period
//   cfg_acc_cycles  : accumulation cycles per pixel (0 behaves as 1)
//   cfg_num_pixels  : pixels per run
//   cfg_pe_mask     : lanes that receive PE_reset / PE_finish
//   ofm_ready       : downstream can accept a pixel result
//   PE_reset        : per-lane accumulator clear pulse
//   PE_finish       : per-lane result strobe
//   pe_hold         : freezes PE accumulation while stalled
//   busy            : a run is in progress
//   done            : one-cycle pulse at completion or abort
//   pixel_idx       : index of the current pixel
//   stall_cycles    : stall performance counter
//
// Every output is a flop; registered outputs are loaded from the next-state
// decode so they line up with the state they describe.

module conv_pe_sequencer #(
  parameter int NUM_PE = 16,
  parameter int CYC_W  = 16,
  parameter int PIX_W  = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cal_start,
  input  logic              abort,
  input  logic [CYC_W-1:0]  cfg_start_delay,
  input  logic [CYC_W-1:0]  cfg_acc_cycles,
  input  logic [PIX_W-1:0]  cfg_num_pixels,
  input  logic [NUM_PE-1:0] cfg_pe_mask,
  input  logic              ofm_ready,
  output logic [NUM_PE-1:0] PE_reset,
  output logic [NUM_PE-1:0] PE_finish,
  output logic              pe_hold,
  output logic              busy,
  output logic              done,
  output logic [PIX_W-1:0]  pixel_idx,
  output logic [31:0]       stall_cycles
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_RST, S_ACC, S_STALL, S_FIN, S_DONE
  } state_t;

  state_t state, next_state;

  logic              cal_start_q;
  logic              start;
  logic [CYC_W-1:0]  delay_q;
  logic [CYC_W-1:0]  acc_q;
  logic [PIX_W-1:0]  npix_q;
  logic [NUM_PE-1:0] mask_q;
  logic [NUM_PE-1:0] mask_eff;
  logic [CYC_W-1:0]  cnt_q;
  logic [CYC_W:0]    cnt_inc;
  logic [CYC_W-1:0]  acc_eff;
  logic [PIX_W:0]    pix_inc;
  logic              wait_last;
  logic              acc_last;
  logic              last_pix;

  assign start     = cal_start && !cal_start_q && (state == S_IDLE);
  assign acc_eff   = (acc_q == '0) ? CYC_W'(1) : acc_q;
  assign cnt_inc   = {1'b0, cnt_q} + 1'b1;
  assign pix_inc   = {1'b0, pixel_idx} + 1'b1;
  assign wait_last = (cnt_inc >= {1'b0, delay_q});
  assign acc_last  = (cnt_inc >= {1'b0, acc_eff});
  assign last_pix  = (pix_inc >= {1'b0, npix_q});

  // The shadow mask is loaded on the same edge that may enter RST directly
  // (zero start delay), so the first pulse must use the incoming mask.
  assign mask_eff  = start ? cfg_pe_mask : mask_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic; abort overrides everything while a run is active.
  // DONE is left alone so the completion pulse stays one cycle wide.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (cfg_num_pixels == '0)       next_state = S_DONE;
          else if (cfg_start_delay == '0) next_state = S_RST;
          else                            next_state = S_WAIT;
        end
      end
      S_WAIT:  if (wait_last) next_state = S_RST;
      S_RST:   next_state = S_ACC;
      S_ACC:   if (acc_last) next_state = ofm_ready ? S_FIN : S_STALL;
      S_STALL: if (ofm_ready) next_state = S_FIN;
      S_FIN:   next_state = last_pix ? S_DONE : S_RST;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (abort && (state != S_IDLE) && (state != S_DONE)) next_state = S_DONE;
  end

  // Start edge history, shadow configuration and per-state cycle counter.
  // The counter restarts on every state change and saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      cal_start_q <= 1'b0;
      delay_q     <= '0;
      acc_q       <= '0;
      npix_q      <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
    end else begin
      cal_start_q <= cal_start;
      if (start) begin
        delay_q <= cfg_start_delay;
        acc_q   <= cfg_acc_cycles;
        npix_q  <= cfg_num_pixels;
        mask_q  <= cfg_pe_mask;
      end
      if (next_state != state)  cnt_q <= '0;
      else if (!cnt_inc[CYC_W]) cnt_q <= cnt_inc[CYC_W-1:0];
    end
  end

  // Registered outputs decoded from the upcoming state; pixel_idx advances
  // as each FIN cycle ends and holds its final value in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      PE_reset  <= '0;
      PE_finish <= '0;
      pe_hold   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pixel_idx <= '0;
    end else begin
      PE_reset  <= (next_state == S_RST) ? mask_eff : '0;
      PE_finish <= (next_state == S_FIN) ? mask_q   : '0;
      pe_hold   <= (next_state == S_STALL);
      busy      <= (next_state != S_IDLE);
      done      <= (next_state == S_DONE);
      if (start)
        pixel_idx <= '0;
      else if ((state == S_FIN) && !pix_inc[PIX_W])
        pixel_idx <= pix_inc[PIX_W-1:0];
    end
  end

`ifdef PE_SEQ_PERF_EN
  // Counts every cycle the sequencer sits in STALL during the current run
  always_ff @(posedge clk) begin
    if (reset || start)
      stall_cycles <= '0;
    else if ((next_state == S_STALL) && (stall_cycles != '1))
      stall_cycles <= stall_cycles + 32'd1;
  end
`else
  assign stall_cycles = '0;
`endif

endmodule
